// File: rtl/bpu_train_unit.sv
// Branch-training retire unit: queues resolved MEM-stage branches and retires each one as a
// gshare PHT read-modify-write plus an optional BTB write, yielding the PHT read port to the front end.
module bpu_train_unit #(
  parameter int DEPTH     = 4,
  parameter int PHT_IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 train_valid_i,
  input  logic                 train_is_branch_i,
  input  logic [31:0]          train_pc_i,
  input  logic [31:0]          train_pred_pc_i,
  input  logic                 train_pred_valid_i,
  input  logic [31:0]          train_ghr_i,
  input  logic                 train_taken_i,
  input  logic [31:0]          train_target_i,
  output logic                 train_ready_o,
  output logic                 train_drop_o,
  input  logic                 bpu_busy_i,
  output logic                 pht_rd_en_o,
  output logic [PHT_IDX_W-1:0] pht_rd_idx_o,
  input  logic [1:0]           pht_rd_data_i,
  output logic                 pht_wr_en_o,
  output logic [PHT_IDX_W-1:0] pht_wr_idx_o,
  output logic [1:0]           pht_wr_data_o,
  output logic                 btb_wr_en_o,
  output logic [31:0]          btb_wr_pc_o,
  output logic [31:0]          btb_wr_target_o,
  output logic                 mispredict_o,
  output logic [31:0]          stat_branches_o,
  output logic [31:0]          stat_mispred_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pred_pc;
    logic [31:0]          target;
    logic [PHT_IDX_W-1:0] ghr;
    logic                 pred_valid;
    logic                 taken;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_e;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          drop_q;
  logic [31:0]   branches_q, branches_d, mispred_q, mispred_d;

  logic                 full, push, pop, upd;
  entry_t               head;
  logic [PHT_IDX_W-1:0] idx;
  logic [31:0]          actual_next;
  logic                 mis, btb_need;
  logic [1:0]           ctr_new;
  logic                 unused_ghr;

  assign unused_ghr = ^train_ghr_i[31:PHT_IDX_W];

  assign full = (count_q == CW'(DEPTH));
  assign push = train_valid_i & train_is_branch_i & ~full;
  assign pop  = (state_q == S_UPDATE);
  // Reset gates the write side combinationally so an entry caught mid-update never lands.
  assign upd  = pop & ~rst;

  assign head        = mem_q[rd_ptr_q];
  assign idx         = head.pc[PHT_IDX_W+1:2] ^ head.ghr;
  assign actual_next = head.taken ? head.target : head.pc + 32'd4;
  assign mis         = head.pred_valid ? (head.pred_pc != actual_next) : head.taken;
  assign btb_need    = head.taken & (~head.pred_valid | (head.pred_pc != head.target));

  always_comb begin
    ctr_new = pht_rd_data_i;
    if (head.taken) begin
      if (pht_rd_data_i != 2'd3) ctr_new = pht_rd_data_i + 2'd1;
    end else begin
      if (pht_rd_data_i != 2'd0) ctr_new = pht_rd_data_i - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_READ;
      S_READ:   if (!bpu_busy_i) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (upd) begin
      if (branches_q != 32'hFFFF_FFFF) branches_d = branches_q + 32'd1;
      if (mis && mispred_q != 32'hFFFF_FFFF) mispred_d = mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= 1'b0;
      branches_q <= '0;
      mispred_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drop_q     <= train_valid_i & train_is_branch_i & full;
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: train_pc_i, pred_pc: train_pred_pc_i, target: train_target_i,
                             ghr: train_ghr_i[PHT_IDX_W-1:0], pred_valid: train_pred_valid_i,
                             taken: train_taken_i};
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign train_ready_o   = ~full;
  assign train_drop_o    = drop_q;
  assign pht_rd_en_o     = (state_q == S_READ) & ~bpu_busy_i & ~rst;
  assign pht_rd_idx_o    = idx;
  assign pht_wr_en_o     = upd;
  assign pht_wr_idx_o    = upd ? idx : '0;
  assign pht_wr_data_o   = upd ? ctr_new : 2'd0;
  assign btb_wr_en_o     = upd & btb_need;
  assign btb_wr_pc_o     = (upd & btb_need) ? head.pc : 32'd0;
  assign btb_wr_target_o = (upd & btb_need) ? head.target : 32'd0;
  assign mispredict_o    = upd & mis;
  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_bpu_train_unit.sv
// Directed bench for bpu_train_unit: vector table for single-entry retirement plus
// hand-written fill/drop, busy-stall and reset-during-update sequences.
module tb_bpu_train_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        train_valid_i, train_is_branch_i, train_pred_valid_i, train_taken_i;
  logic [31:0] train_pc_i, train_pred_pc_i, train_ghr_i, train_target_i;
  logic        train_ready_o, train_drop_o, bpu_busy_i;
  logic        pht_rd_en_o, pht_wr_en_o, btb_wr_en_o, mispredict_o;
  logic [7:0]  pht_rd_idx_o, pht_wr_idx_o;
  logic [1:0]  pht_rd_data_i, pht_wr_data_o;
  logic [31:0] btb_wr_pc_o, btb_wr_target_o, stat_branches_o, stat_mispred_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bpu_train_unit #(.DEPTH(4), .PHT_IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .train_valid_i(train_valid_i), .train_is_branch_i(train_is_branch_i),
    .train_pc_i(train_pc_i), .train_pred_pc_i(train_pred_pc_i),
    .train_pred_valid_i(train_pred_valid_i), .train_ghr_i(train_ghr_i),
    .train_taken_i(train_taken_i), .train_target_i(train_target_i),
    .train_ready_o(train_ready_o), .train_drop_o(train_drop_o),
    .bpu_busy_i(bpu_busy_i),
    .pht_rd_en_o(pht_rd_en_o), .pht_rd_idx_o(pht_rd_idx_o), .pht_rd_data_i(pht_rd_data_i),
    .pht_wr_en_o(pht_wr_en_o), .pht_wr_idx_o(pht_wr_idx_o), .pht_wr_data_o(pht_wr_data_o),
    .btb_wr_en_o(btb_wr_en_o), .btb_wr_pc_o(btb_wr_pc_o), .btb_wr_target_o(btb_wr_target_o),
    .mispredict_o(mispredict_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  typedef struct {
    logic [31:0] pc, ghr, ppc, tgt;
    logic        taken, pv;
    logic [1:0]  pht;
    logic [7:0]  idx;
    logic [1:0]  wr;
    logic        btb, mis;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] ghr, input logic taken,
                              input logic pv, input logic [31:0] ppc, input logic [31:0] tgt);
    train_valid_i      = 1'b1;
    train_is_branch_i  = 1'b1;
    train_pc_i         = pc;
    train_ghr_i        = ghr;
    train_taken_i      = taken;
    train_pred_valid_i = pv;
    train_pred_pc_i    = ppc;
    train_target_i     = tgt;
  endtask

  // Looks at the current cycle first, then advances; bounded so a stuck FSM cannot hang the run.
  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (pht_rd_en_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit          ok;
    int          exp_br, exp_mr;
    logic [31:0] cyc_rd;

    vecs[0] = '{32'h100,      32'h03,        32'h0,   32'h200, 1'b1, 1'b0, 2'd1, 8'h43, 2'd2, 1'b1, 1'b1};
    vecs[1] = '{32'h100,      32'h03,        32'h200, 32'h200, 1'b1, 1'b1, 2'd3, 8'h43, 2'd3, 1'b0, 1'b0};
    vecs[2] = '{32'h100,      32'h03,        32'h200, 32'h200, 1'b0, 1'b1, 2'd0, 8'h43, 2'd0, 1'b0, 1'b1};
    vecs[3] = '{32'h1234,     32'hFFFF_FF0F, 32'h0,   32'h40,  1'b0, 1'b0, 2'd2, 8'h82, 2'd1, 1'b0, 1'b0};
    vecs[4] = '{32'h2000,     32'h00,        32'h300, 32'h200, 1'b1, 1'b1, 2'd2, 8'h00, 2'd3, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 32'h55,       32'h0,   32'h10,  1'b0, 1'b1, 2'd1, 8'hAA, 2'd0, 1'b0, 1'b0};

    rst = 1'b1;
    train_valid_i = 1'b0; train_is_branch_i = 1'b0; train_pred_valid_i = 1'b0; train_taken_i = 1'b0;
    train_pc_i = '0; train_pred_pc_i = '0; train_ghr_i = '0; train_target_i = '0;
    bpu_busy_i = 1'b0; pht_rd_data_i = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", train_ready_o, 1);
    chk("rst_drop", train_drop_o, 0);
    chk("rst_rd_en", pht_rd_en_o, 0);
    chk("rst_rd_idx", pht_rd_idx_o, 0);
    chk("rst_wr_en", pht_wr_en_o, 0);
    chk("rst_wr_idx", pht_wr_idx_o, 0);
    chk("rst_btb_en", btb_wr_en_o, 0);
    chk("rst_btb_pc", btb_wr_pc_o, 0);
    chk("rst_mispred", mispredict_o, 0);
    chk("rst_stat_br", stat_branches_o, 0);
    chk("rst_stat_mr", stat_mispred_o, 0);

    // A non-branch bundle is ignored entirely.
    @(negedge clk);
    train_valid_i = 1'b1; train_is_branch_i = 1'b0; train_pc_i = 32'h900;
    @(negedge clk);
    train_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("nonbr_rd_en", pht_rd_en_o, 0);
      chk("nonbr_drop", train_drop_o, 0);
    end

    exp_br = 0;
    exp_mr = 0;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drive_branch(vecs[v].pc, vecs[v].ghr, vecs[v].taken, vecs[v].pv, vecs[v].ppc, vecs[v].tgt);
      pht_rd_data_i = vecs[v].pht;
      @(negedge clk);
      train_valid_i = 1'b0;
      wait_rd(ok);
      chk("vec_rd_seen", 32'(ok), 1);
      chk("vec_rd_idx", pht_rd_idx_o, vecs[v].idx);
      @(negedge clk); #1;
      chk("vec_wr_en", pht_wr_en_o, 1);
      chk("vec_wr_idx", pht_wr_idx_o, vecs[v].idx);
      chk("vec_wr_data", pht_wr_data_o, vecs[v].wr);
      chk("vec_btb_en", btb_wr_en_o, vecs[v].btb);
      chk("vec_btb_pc", btb_wr_pc_o, vecs[v].btb ? vecs[v].pc : 32'h0);
      chk("vec_btb_tgt", btb_wr_target_o, vecs[v].btb ? vecs[v].tgt : 32'h0);
      chk("vec_mispred", mispredict_o, vecs[v].mis);
      exp_br++;
      if (vecs[v].mis) exp_mr++;
      @(negedge clk); #1;
      chk("vec_wr_done", pht_wr_en_o, 0);
      chk("vec_stat_br", stat_branches_o, exp_br);
      chk("vec_stat_mr", stat_mispred_o, exp_mr);
    end

    // Fill with the front end holding the PHT port: 4 accepted, 5th dropped.
    bpu_busy_i = 1'b1;
    pht_rd_data_i = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("fill_ready", train_ready_o, (k < 4) ? 1 : 0);
      chk("fill_rd_busy", pht_rd_en_o, 0);
      drive_branch(32'h1000 + 32'(16 * k), 32'h0, 1'b1, 1'b0, 32'h0, 32'h2000 + 32'(16 * k));
    end
    @(negedge clk); #1;
    train_valid_i = 1'b0;
    chk("fill_drop", train_drop_o, 1);
    chk("fill_full", train_ready_o, 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("fill_drop_pulse", train_drop_o, 0);
      chk("busy_no_rd", pht_rd_en_o, 0);
    end

    @(negedge clk);
    bpu_busy_i = 1'b0;
    cyc_rd = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rd(ok);
      chk("drain_rd_seen", 32'(ok), 1);
      chk("drain_rd_idx", pht_rd_idx_o, 32'(4 * k));
      @(negedge clk); #1;
      chk("drain_wr_next", pht_wr_en_o, 1);
      chk("drain_order", btb_wr_pc_o, 32'h1000 + 32'(16 * k));
      chk("drain_wr_data", pht_wr_data_o, 1);
      cyc_rd++;
    end
    exp_br += 4;
    exp_mr += 4;
    repeat (5) begin
      @(negedge clk); #1;
      chk("drain_empty_rd", pht_rd_en_o, 0);
    end
    chk("drain_count", cyc_rd, 4);
    chk("drain_ready", train_ready_o, 1);
    chk("drain_stat_br", stat_branches_o, exp_br);
    chk("drain_stat_mr", stat_mispred_o, exp_mr);

    // Reset lands on the UPDATE cycle of an entry that would write both PHT and BTB.
    @(negedge clk);
    drive_branch(32'h500, 32'h0, 1'b1, 1'b0, 32'h0, 32'h600);
    @(negedge clk);
    train_valid_i = 1'b0;
    wait_rd(ok);
    chk("rstupd_rd_seen", 32'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstupd_wr_en", pht_wr_en_o, 0);
    chk("rstupd_btb_en", btb_wr_en_o, 0);
    chk("rstupd_mispred", mispredict_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstupd_stat_br", stat_branches_o, 0);
    chk("rstupd_stat_mr", stat_mispred_o, 0);
    chk("rstupd_ready", train_ready_o, 1);
    repeat (4) begin
      @(negedge clk); #1;
      chk("rstupd_no_wr", pht_wr_en_o, 0);
      chk("rstupd_no_rd", pht_rd_en_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
